// File: rtl/mips_io_pkg.sv
// Shared definitions for the MIPS memory-mapped I/O blocks: serialiser state
// encoding and the default store addresses of the UART transmitter.
package mips_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [31:0] TX_ADDR_DEFAULT   = 32'hFFFF_FFF0;
  localparam logic [31:0] CTRL_ADDR_DEFAULT = 32'hFFFF_FFF4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read port; pointers carry one extra wrap
// bit so full and empty are told apart without a separate count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/store_uart_tx.sv
// Store-snooping UART transmitter: byte stores to TX_ADDR are queued and sent
// as 8N1 frames; a store of bit0=1 to CTRL_ADDR clears the sticky overflow.
module store_uart_tx
  import mips_io_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = TX_ADDR_DEFAULT,
  parameter logic [31:0] CTRL_ADDR    = CTRL_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_nx;
  logic [CW-1:0] baud, baud_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          tx_q, tx_nx;
  logic          ovf_q;
  logic          bit_end;
  logic          pop;
  logic          tx_store;
  logic          ctrl_clear;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic          unused_wdata_hi;

  assign tx_store        = memwrite && (dataadr == TX_ADDR);
  assign ctrl_clear      = memwrite && (dataadr == CTRL_ADDR) && writedata[0];
  assign drop            = tx_store && fifo_full && !pop;
  assign bit_end         = (baud == BIT_LAST);
  assign unused_wdata_hi = ^writedata[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_store),
    .pop   (pop),
    .wdata (writedata[7:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nx   = state;
    baud_nx    = bit_end ? '0 : baud + CW'(1);
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_nx = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shreg_nx = fifo_head;
          state_nx = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx   = DATA;
          bit_idx_nx = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_nx = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_idx_nx = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            shreg_nx = fifo_head;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Line level is chosen from the upcoming state so tx stays a pure flop.
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      tx_q    <= tx_nx;
      if (drop)            ovf_q <= 1'b1;
      else if (ctrl_clear) ovf_q <= 1'b0;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state != IDLE) || !fifo_empty;
  assign full     = fifo_full;
  assign overflow = ovf_q;

endmodule
